sorted_array_builder: RTL and testbench

//  Builds a sorted 32 x 8 array of unsigned bytes, one insertion at a time (insertion sort).

---
 rtl/sorted_array_builder_if.sv | 27 ++
 rtl/sorted_array_builder.sv | 124 ++++++++++++
 tb/tb_sorted_array_builder.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sorted_array_builder_if.sv
// Interface bundling the insert handshake, clear, read port and status
// of the sorted array builder. master = front end / search side, slave = builder.
interface sorted_array_builder_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
);
  logic              ins_valid;
  logic [DATA_W-1:0] ins_data;
  logic              ins_ready;
  logic              clear;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              busy;
  logic              ins_dup;

  modport master (
    output ins_valid, ins_data, clear, rd_addr,
    input  ins_ready, rd_data, count, full, busy, ins_dup
  );

  modport slave (
    input  ins_valid, ins_data, clear, rd_addr,
    output ins_ready, rd_data, count, full, busy, ins_dup
  );
endinterface

// File: rtl/sorted_array_builder.sv
// Sorted array builder: keeps a DEPTH x DATA_W array of unsigned values in
// ascending order, one insertion-sort step per cycle, with a combinational
// read port for the downstream search datapath.
// Optional feature macro: DUP_REJECT_EN -- rejects values already present,
// restoring the array through an UNDO pass and pulsing ins_dup.
module sorted_array_builder #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input logic                clock,
  input logic                reset,
  sorted_array_builder_if.slave bus
);
  localparam int              DEPTH   = 2**ADDR_W;
  localparam logic [ADDR_W:0] CNT_MAX = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE     = (ADDR_W+1)'(1);

`ifdef DUP_REJECT_EN
  typedef enum logic [1:0] {IDLE, SHIFT, WRITE, UNDO} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT, WRITE} state_t;
`endif

  state_t                   state;
  logic [DATA_W-1:0]        mem [DEPTH];
  logic [ADDR_W:0]          cnt;
  logic [DATA_W-1:0]        val;
  logic signed [ADDR_W:0]   i;      // scan index, -1 means "below slot 0"
  logic [ADDR_W-1:0]        i_a;
  logic [ADDR_W-1:0]        i1_a;   // slot above the scan index (wraps -1 to 0)
  logic                     ready;
  logic                     accept;
`ifdef DUP_REJECT_EN
  logic [ADDR_W-1:0]        j;      // restore pointer for UNDO
  logic                     dup_q;
`endif

  assign i_a    = i[ADDR_W-1:0];
  assign i1_a   = i_a + 1'b1;
  assign ready  = (state == IDLE) && (cnt < CNT_MAX);
  // clear outranks a simultaneous insert request
  assign accept = bus.ins_valid & ready & ~bus.clear;

  assign bus.ins_ready = ready;
  assign bus.rd_data   = mem[bus.rd_addr];
  assign bus.count     = cnt;
  assign bus.full      = (cnt == CNT_MAX);
  assign bus.busy      = (state != IDLE);
`ifdef DUP_REJECT_EN
  assign bus.ins_dup   = dup_q;
`else
  assign bus.ins_dup   = 1'b0;
`endif

  // Insertion FSM and array storage: shift larger entries up one per cycle,
  // then drop the new value into the hole.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
      cnt   <= '0;
      val   <= '0;
      i     <= '0;
      state <= IDLE;
`ifdef DUP_REJECT_EN
      j     <= '0;
      dup_q <= 1'b0;
`endif
    end else begin
`ifdef DUP_REJECT_EN
      dup_q <= 1'b0;
`endif
      if (bus.clear) begin
        for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
        cnt   <= '0;
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (accept) begin
              val   <= bus.ins_data;
              i     <= $signed(cnt - ONE);   // empty array gives -1
              state <= (cnt == '0) ? WRITE : SHIFT;
            end
          end
          SHIFT: begin
            // the exhausted-index check costs a cycle so latency is always k+2
            if (i[ADDR_W]) begin
              state <= WRITE;
            end else if (mem[i_a] > val) begin
              mem[i1_a] <= mem[i_a];
              i         <= i - ONE;
`ifdef DUP_REJECT_EN
            end else if (mem[i_a] == val) begin
              dup_q <= 1'b1;
              j     <= i1_a;
              state <= UNDO;
`endif
            end else begin
              state <= WRITE;
            end
          end
          WRITE: begin
            mem[i1_a] <= val;
            cnt       <= cnt + ONE;
            state     <= IDLE;
          end
`ifdef DUP_REJECT_EN
          UNDO: begin
            // slide shifted entries back down, then clear the vacated top slot
            if (j == cnt[ADDR_W-1:0]) begin
              mem[j] <= '0;
              state  <= IDLE;
            end else begin
              mem[j] <= mem[j + 1'b1];
              j      <= j + 1'b1;
            end
          end
`endif
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_sorted_array_builder.sv
// Bench for sorted_array_builder: table-driven directed sequence, corner
// sequences (full, best/worst latency, clear, async reset) and randomized
// inserts checked against a queue-based sorted-list model.
module tb_sorted_array_builder;
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  sorted_array_builder_if bus ();
  sorted_array_builder dut (.clock(clock), .reset(reset), .bus(bus));

  int errors = 0;
  int checks = 0;
  int model[$];

  typedef struct {
    logic [7:0] val;
    int         lat;
    int         cnt;
    int         dup;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: sorted list; new value goes after all values <= it.
  // Latency = edges after accept until idle.
  function automatic void model_insert(input int v, output int lat, output int dup);
    int k = 0;
`ifdef DUP_REJECT_EN
    bit has = 0;
    foreach (model[n]) if (model[n] == v) has = 1;
`endif
    foreach (model[n]) if (model[n] > v) k++;
    dup = 0;
`ifdef DUP_REJECT_EN
    if (has) begin
      dup = 1;
      lat = 2*k + 2;
      return;
    end
`endif
    lat = (model.size() == 0) ? 1 : k + 2;
    model.insert(model.size() - k, v);
  endfunction

  task automatic drive_insert(input logic [7:0] v, output int lat, output int dups);
    @(negedge clock);
    bus.ins_valid = 1'b1;
    bus.ins_data  = v;
    @(posedge clock); #1;
    bus.ins_valid = 1'b0;
    lat  = 0;
    dups = int'(bus.ins_dup);
    while (bus.busy && lat < 200) begin
      @(posedge clock); #1;
      lat++;
      dups += int'(bus.ins_dup);
    end
    if (lat >= 200) chk("insert_timeout", 1, 0);
  endtask

  task automatic ins_model(input logic [7:0] v, output int lat);
    int el, ed, d;
    chk("ready_before_insert", bus.ins_ready, 1);
    model_insert(int'(v), el, ed);
    drive_insert(v, lat, d);
    chk("latency", lat, el);
    chk("dup_pulses", d, ed);
  endtask

  task automatic check_array(input string name);
    chk({name, "_count"}, bus.count, model.size());
    chk({name, "_full"}, bus.full, model.size() == 32);
    chk({name, "_busy"}, bus.busy, 0);
    for (int a = 0; a < 32; a++) begin
      bus.rd_addr = 5'(a);
      #1;
      chk($sformatf("%s_mem[%0d]", name, a), bus.rd_data, (a < model.size()) ? model[a] : 0);
    end
  endtask

  task automatic do_clear();
    @(negedge clock);
    bus.clear = 1'b1;
    @(posedge clock); #1;
    bus.clear = 1'b0;
    model.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tv[4];
    logic [7:0] exp_mem[4];
    int lat, d, el, ed;

    bus.ins_valid = 1'b0;
    bus.ins_data  = '0;
    bus.clear     = 1'b0;
    bus.rd_addr   = '0;

    // reset state
    #12;
    chk("rst_busy", bus.busy, 0);
    chk("rst_full", bus.full, 0);
    chk("rst_dup", bus.ins_dup, 0);
    chk("rst_ready", bus.ins_ready, 1);
    chk("rst_count", bus.count, 0);
    @(negedge clock);
    reset = 1'b1;
    check_array("reset");

    // directed 5,3,9,3
    tv[0] = '{8'd5, 1, 1, 0};
    tv[1] = '{8'd3, 3, 2, 0};
    tv[2] = '{8'd9, 2, 3, 0};
`ifdef DUP_REJECT_EN
    tv[3] = '{8'd3, 6, 3, 1};
    exp_mem = '{8'd3, 8'd5, 8'd9, 8'd0};
`else
    tv[3] = '{8'd3, 4, 4, 0};
    exp_mem = '{8'd3, 8'd3, 8'd5, 8'd9};
`endif
    for (int n = 0; n < 4; n++) begin
      drive_insert(tv[n].val, lat, d);
      model_insert(int'(tv[n].val), el, ed);
      chk($sformatf("tbl_lat[%0d]", n), lat, tv[n].lat);
      chk($sformatf("tbl_cnt[%0d]", n), bus.count, tv[n].cnt);
      chk($sformatf("tbl_dup[%0d]", n), d, tv[n].dup);
    end
    for (int a = 0; a < 4; a++) begin
      bus.rd_addr = 5'(a);
      #1;
      chk($sformatf("tbl_mem[%0d]", a), bus.rd_data, exp_mem[a]);
    end
    check_array("tbl");

    // worst case: 200..170 descending, then 0 into 31 entries
    do_clear();
    for (int v = 200; v >= 170; v--) ins_model(8'(v), lat);
    ins_model(8'd0, lat);
    chk("worst_lat", lat, 33);
    bus.rd_addr = 5'd0;  #1; chk("worst_mem0", bus.rd_data, 0);
    bus.rd_addr = 5'd31; #1; chk("worst_mem31", bus.rd_data, 200);
    chk("full_flag", bus.full, 1);
    chk("full_ready", bus.ins_ready, 0);
    @(negedge clock);
    bus.ins_valid = 1'b1;
    bus.ins_data  = 8'd7;
    repeat (3) begin
      @(posedge clock); #1;
      chk("full_no_busy", bus.busy, 0);
    end
    bus.ins_valid = 1'b0;
    check_array("full_hold");

    // best case: 255 into 10 entries
    do_clear();
    for (int n = 0; n < 10; n++) ins_model(8'(n*10 + 20), lat);
    ins_model(8'd255, lat);
    chk("best_lat", lat, 2);
    bus.rd_addr = 5'd10; #1;
    chk("best_mem10", bus.rd_data, 255);
    chk("best_count", bus.count, 11);

    // clear during SHIFT
    do_clear();
    for (int n = 0; n < 20; n++) ins_model(8'(50 + n), lat);
    @(negedge clock);
    bus.ins_valid = 1'b1;
    bus.ins_data  = 8'd0;
    @(posedge clock); #1;
    bus.ins_valid = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    chk("mid_shift_busy", bus.busy, 1);
    @(negedge clock);
    bus.clear = 1'b1;
    @(posedge clock); #1;
    bus.clear = 1'b0;
    chk("clr_count", bus.count, 0);
    chk("clr_busy", bus.busy, 0);
    model.delete();
    check_array("after_clear");

    // clear together with ins_valid: clear wins
    @(negedge clock);
    bus.clear     = 1'b1;
    bus.ins_valid = 1'b1;
    bus.ins_data  = 8'd9;
    @(posedge clock); #1;
    bus.clear     = 1'b0;
    bus.ins_valid = 1'b0;
    chk("clr_vs_ins_busy", bus.busy, 0);
    chk("clr_vs_ins_count", bus.count, 0);

    // randomized inserts against the model
    for (int r = 0; r < 2; r++) begin
      do_clear();
      for (int n = 0; n < 45; n++) begin
        logic [7:0] v;
        v = 8'($urandom_range(0, 60));
        if (model.size() < 32) ins_model(v, lat);
        else chk("rand_full_ready", bus.ins_ready, 0);
      end
      check_array($sformatf("rand%0d", r));
    end

    // async reset mid-insert
    do_clear();
    for (int n = 0; n < 6; n++) ins_model(8'(100 + n), lat);
    @(negedge clock);
    bus.ins_valid = 1'b1;
    bus.ins_data  = 8'd1;
    @(posedge clock); #1;
    bus.ins_valid = 1'b0;
    @(posedge clock); #3;
    reset = 1'b0;
    #1;
    chk("arst_busy", bus.busy, 0);
    chk("arst_count", bus.count, 0);
    chk("arst_full", bus.full, 0);
    chk("arst_ready", bus.ins_ready, 1);
    chk("arst_dup", bus.ins_dup, 0);
    for (int a = 0; a < 4; a++) begin
      bus.rd_addr = 5'(a);
      #1;
      chk($sformatf("arst_mem[%0d]", a), bus.rd_data, 0);
    end
    @(negedge clock);
    reset = 1'b1;
    model.delete();
    check_array("post_arst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
